// File: rtl/iir_inv_filter_pkg.sv
// Shared definitions for the IIR filter pair (IIR_filter / iir_inv_filter).
// Holds the FSM state encoding, data and accumulator widths, and the
// Baugh-Wooley correction constant for a DATA_W x DATA_W signed product.
package iir_inv_filter_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned ACC_W  = 8;
    localparam int unsigned ROW_W  = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        OUT
    } state_t;

    // Restores the weight removed by the inverted sign-row bits:
    // 2^DATA_W + 2^(2*DATA_W-1).
    localparam logic [ACC_W-1:0] BW_CORR = ACC_W'((1 << DATA_W) + (1 << (2 * DATA_W - 1)));

endpackage

// File: rtl/iir_inv_filter_bw_pp_row.sv
// bw_pp_row: one Baugh-Wooley partial-product row, purely combinational.
// Ports:
//   mcand [DATA_W-1:0]  signed multiplicand
//   mbit                multiplier bit selected for this row
//   row   [ROW_W-1:0]   row index (multiplier bit position)
//   pp    [ACC_W-1:0]   row shifted into place, sign-row bits inverted
module bw_pp_row
    import iir_inv_filter_pkg::*;
(
    input  logic [DATA_W-1:0] mcand,
    input  logic              mbit,
    input  logic [ROW_W-1:0]  row,
    output logic [ACC_W-1:0]  pp
);

    logic [DATA_W-1:0] bits;
    logic              sign_row;

    always_comb begin
        bits     = '0;
        sign_row = (row == ROW_W'(DATA_W - 1));
        // Invert a bit when exactly one of its factors is a sign bit;
        // the sign x sign term keeps its positive weight.
        for (int unsigned j = 0; j < DATA_W; j++) begin
            bits[j] = (mcand[j] & mbit) ^ (sign_row ^ (j == DATA_W - 1));
        end
        pp = ACC_W'(bits) << row;
    end

endmodule

// File: rtl/iir_inv_filter.sv
// iir_inv_filter: inverts IIR_filter, recovering x[n] = y[n] - (a*y[n-1])[3:0].
// The product is built serially, one Baugh-Wooley row per cycle.
// Ports:
//   clk, rst (async, active-high)
//   in_valid/in_ready   input handshake for y_in, a, in_first
//   y_in  [3:0]         filtered sample y[n]
//   a     [3:0]         feedback coefficient
//   in_first            first sample of a stream (history treated as zero)
//   out_valid/out_ready output handshake for x_out
//   x_out [3:0]         recovered sample x[n]
module iir_inv_filter
    import iir_inv_filter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] y_in,
    input  logic [DATA_W-1:0] a,
    input  logic              in_first,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] x_out
);

    state_t            state, state_next;
    logic [DATA_W-1:0] y_lat, a_lat, mcand, y_prev;
    logic [ACC_W-1:0]  acc, pp, acc_sum;
    logic [ROW_W-1:0]  row;
    logic              last_row;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign last_row  = (row == ROW_W'(DATA_W - 1));

    bw_pp_row u_row (
        .mcand (mcand),
        .mbit  (a_lat[row]),
        .row   (row),
        .pp    (pp)
    );

    // Correction constant folds in with the final row.
    assign acc_sum = acc + pp + (last_row ? BW_CORR : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = MUL;
            MUL:     if (last_row)  state_next = OUT;
            OUT:     if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_lat  <= '0;
            a_lat  <= '0;
            mcand  <= '0;
            y_prev <= '0;
            acc    <= '0;
            row    <= '0;
            x_out  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        y_lat <= y_in;
                        a_lat <= a;
                        mcand <= in_first ? '0 : y_prev;
                        acc   <= '0;
                        row   <= '0;
                    end
                end
                MUL: begin
                    acc <= acc_sum;
                    row <= row + ROW_W'(1);
                    if (last_row) begin
                        x_out  <= y_lat - acc_sum[DATA_W-1:0];
                        y_prev <= y_lat;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iir_inv_filter.sv
// Testbench for iir_inv_filter: directed cases plus a closed loop through a
// behavioural IIR_filter model; expected samples are queued on accept and
// compared when out_valid appears.
module tb_iir_inv_filter;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] y_in;
    logic [3:0] a;
    logic       in_first;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] x_out;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_q[$];

    iir_inv_filter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y_in      (y_in),
        .a         (a),
        .in_first  (in_first),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] prod_lo(input logic [3:0] c, input logic [3:0] v);
        int p;
        p = $signed(c) * $signed(v);
        return p[3:0];
    endfunction

    // Drive one sample, wait for its result, optionally hold off out_ready
    // for 'hold' cycles with in_valid asserted.
    task automatic send(input logic first, input logic [3:0] ca, input logic [3:0] cy,
                        input logic [3:0] expx, input int hold, input logic chk_lat);
        int         edges;
        int         w;
        logic [3:0] held;
        logic [3:0] e;
        @(negedge clk);
        in_valid = 1'b1;
        in_first = first;
        a        = ca;
        y_in     = cy;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(expx);
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        in_valid = 1'b0;
        in_first = 1'b0;
        while (!out_valid && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        if (chk_lat) check("latency_edges", edges, 5);
        if (!out_valid) begin
            check("out_valid_timeout", 0, 1);
            void'(exp_q.pop_front());
            return;
        end
        if (exp_q.size() == 0) begin
            check("sb_empty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            check("x_out", int'(x_out), int'(e));
        end
        check("in_ready_in_out", int'(in_ready), 0);
        held = x_out;
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            in_first = first;
            @(negedge clk);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_x_stable", int'(x_out), int'(held));
        end
        in_valid  = 1'b0;
        in_first  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_clear", int'(out_valid), 0);
        check("in_ready_idle", int'(in_ready), 1);
    endtask

    initial begin
        logic [3:0] xr;
        logic [3:0] ar;
        logic [3:0] yr;
        logic [3:0] yf;
        logic       fr;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        a         = '0;
        y_in      = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_x_out", int'(x_out), 0);
        rst = 1'b0;

        send(1'b1, 4'd3, 4'd2, 4'd2, 0, 1'b1);
        send(1'b0, 4'd3, 4'd5, 4'hF, 0, 1'b1);
        send(1'b0, 4'hE, 4'd7, 4'd1, 0, 1'b1);

        // y_prev = -8, then a = -8: product +64 has a zero low nibble.
        send(1'b1, 4'd0, 4'd8, 4'd8, 0, 1'b0);
        send(1'b0, 4'h8, 4'd3, 4'd3, 10, 1'b1);
        // History is 3: 4 - (3*3)[3:0] = 4 - 9 = -5.
        send(1'b0, 4'd3, 4'd4, 4'hB, 0, 1'b0);

        // Reset in the middle of a multiply discards it and clears history.
        @(negedge clk);
        in_valid = 1'b1;
        in_first = 1'b0;
        a        = 4'd7;
        y_in     = 4'd9;
        @(negedge clk);
        in_valid = 1'b0;
        check("mid_accept", int'(in_ready), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", int'(in_ready), 1);
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_x_out", int'(x_out), 0);
        rst = 1'b0;
        send(1'b0, 4'd5, 4'd6, 4'd6, 0, 1'b1);

        // Closed loop through a forward IIR_filter model.
        yf = '0;
        for (int i = 0; i < 1000; i++) begin
            xr = 4'($urandom);
            ar = 4'($urandom);
            fr = (i == 0);
            yr = xr + prod_lo(ar, fr ? 4'd0 : yf);
            yf = yr;
            send(fr, ar, yr, xr, 0, 1'b0);
        end

        check("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iir_inv_filter.md
IIR_INV_FILTER -- requirements
Module: iir_inv_filter

Interface
REQ-001 The block SHALL have no parameters; sample and coefficient width are fixed at 4 bits, signed two's complement.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  y_in/a/in_first carry a valid sample.
REQ-005 in_ready  output  1  block can accept a sample.
REQ-006 y_in  input  4  filtered sample y[n], the stream produced by IIR_filter.
REQ-007 a  input  4  feedback coefficient, sampled with each accepted sample.
REQ-008 in_first  input  1  marks the first sample of a stream; history is treated as zero.
REQ-009 out_valid  output  1  x_out holds a recovered sample.
REQ-010 out_ready  input  1  downstream accepts x_out.
REQ-011 x_out  output  4  recovered input sample x[n].

Function
REQ-012 The block SHALL compute x[n] = (y[n] - P[3:0]) mod 16, where P = a*y[n-1] as a signed Baugh-Wooley product; this exactly inverts IIR_filter's y[n] = x[n] + P[3:0].
REQ-013 The block SHALL form P over 4 cycles: one Baugh-Wooley partial-product row per cycle into an 8-bit accumulator, with the sign-row inversions and correction constant applied; only P[3:0] is consumed.
REQ-014 FSM states: IDLE, MUL, OUT.
REQ-015 in_ready SHALL be 1 only in IDLE.
REQ-016 In IDLE, on in_valid=1, the block SHALL latch y_in, a, and the multiplicand (y_prev, or 0 if in_first=1), clear the accumulator and the row counter, and go to MUL.
REQ-017 In MUL, the block SHALL add row i (i=0..3) on each edge; after row 3 it SHALL register x_out, copy the latched y_in to y_prev, set out_valid=1, and go to OUT.
REQ-018 Latency SHALL be 5 edges from the accept edge to out_valid=1. Minimum sample interval: 6 cycles.
REQ-019 In OUT, out_valid and x_out SHALL stay stable until out_ready=1; on that edge out_valid SHALL clear and the FSM SHALL return to IDLE.
REQ-020 in_valid in MUL or OUT SHALL be ignored (no accept); the source SHALL hold its sample.
REQ-021 Subtraction and product SHALL wrap modulo 16 and 256 respectively; no saturation and no overflow flag.
REQ-022 a=-8 with y_prev=-8 (P=+64) SHALL give P[3:0]=0 with no special casing.
REQ-023 in_first SHALL affect only the sample it accompanies; y_prev SHALL update only when a result is produced.

Reset
REQ-024 While rst=1: FSM=IDLE, in_ready=1, out_valid=0, x_out=0, y_prev=0, accumulator=0, row counter=0.
REQ-025 rst asserted mid-MUL or mid-OUT SHALL discard the sample in progress; the first sample after reset SHALL use y_prev=0.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding, the 4-bit data width, and the 8-bit accumulator width, shared with IIR_filter.
REQ-027 One sub-module, bw_pp_row, SHALL be combinational; it takes the multiplicand, one multiplier bit and the row index, and returns the shifted Baugh-Wooley row including the sign-bit inversions.

Verification
REQ-028 Reset, then a=3, y_in=2, in_first=1 -> x_out=2, with out_valid rising 5 edges after accept.
REQ-029 Continue: a=3, y_in=5 -> x_out=4'hF (-1); then a=-2 (4'hE), y_in=7 -> x_out=1.
REQ-030 Corner case: y_prev=-8 (in_first, a=0, y_in=8), then a=-8, y_in=3 -> x_out=3.
REQ-031 Back-pressure: hold out_ready=0 for 10 cycles while in_valid=1 -> x_out stable, in_ready=0, no second accept.
REQ-032 Assert rst during MUL, then send in_first=0, a=5, y_in=6 -> x_out=6 (history cleared).
REQ-033 Closed loop: a random x stream through IIR_filter, then this block with in_first on the first sample -> recovered x equals the original for 1000 samples and random a.
